// File: rtl/rf_write_arbiter_if.sv
// Write-port bus between the two requesters (writeback, multi-cycle unit) and the
// register-file write arbiter, including the arbiter's registered regfile write outputs.
interface rf_write_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          a_ready;
    logic          a_stall;

    logic          b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          b_ready;

    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  a_ready, a_stall, b_ready,
        input  rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output a_ready, a_stall, b_ready,
        output rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port between writeback (A, fixed priority) and the multi-cycle
// unit (B, starvation-forced grant). Optional statistics counters under RF_WR_STATS_EN.
module rf_write_arbiter #(
    parameter int AW           = 5,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    rf_write_arbiter_if.slave  bus
`ifdef RF_WR_STATS_EN
    ,
    output logic [CNT_W-1:0]   stat_a_grants,
    output logic [CNT_W-1:0]   stat_b_grants,
    output logic [CNT_W-1:0]   stat_stall_cycles
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]    wait_cnt;
    logic          force_b;
    logic          a_acc;
    logic          b_acc;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_data;

    // Arbitration is purely a function of current requests and registered starvation state.
    assign force_b     = (wait_cnt == LIMIT);
    assign bus.a_ready = reset_n & ~force_b;
    assign bus.b_ready = reset_n & (force_b | ~bus.a_valid);
    assign bus.a_stall = bus.a_valid & ~bus.a_ready;

    assign a_acc = bus.a_valid & bus.a_ready;
    assign b_acc = bus.b_valid & bus.b_ready;

    always_comb begin
        grant_addr = bus.b_addr;
        grant_data = bus.b_data;
        if (a_acc) begin
            grant_addr = bus.a_addr;
            grant_data = bus.a_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!bus.b_valid || b_acc) begin
            wait_cnt <= '0;
        end else if (wait_cnt != LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Output stage: granted write is presented one cycle after acceptance; r0 writes are dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.rf_we <= 1'b0;
            bus.rf_wa <= '0;
            bus.rf_wd <= '0;
        end else if (a_acc || b_acc) begin
            bus.rf_we <= (grant_addr != '0);
            bus.rf_wa <= grant_addr;
            bus.rf_wd <= grant_data;
        end else begin
            bus.rf_we <= 1'b0;
        end
    end

`ifdef RF_WR_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_a_grants     <= '0;
            stat_b_grants     <= '0;
            stat_stall_cycles <= '0;
        end else begin
            stat_a_grants     <= sat_inc(stat_a_grants, a_acc);
            stat_b_grants     <= sat_inc(stat_b_grants, b_acc);
            stat_stall_cycles <= sat_inc(stat_stall_cycles, bus.a_stall);
        end
    end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed scenarios plus randomized traffic against
// a behavioural model of the grant rules and a shadow register file.
module tb_rf_write_arbiter;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.AW(AW), .DW(DW)) bus();

`ifdef RF_WR_STATS_EN
    logic [CNT_W-1:0] sa, sb, ss;
`endif

    rf_write_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef RF_WR_STATS_EN
        ,
        .stat_a_grants     (sa),
        .stat_b_grants     (sb),
        .stat_stall_cycles (ss)
`endif
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    logic [DW-1:0] rf_mem [32];
    logic [DW-1:0] ref_rf [32];
    int  lost = 0;
    bit  got_a, got_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic record(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t e;
        if (addr != '0) begin
            e.addr = addr;
            e.data = data;
            exp_q.push_back(e);
            ref_rf[addr] = data;
        end
    endtask

    // One clock cycle: drive after posedge, then at negedge predict and check the handshake.
    task automatic step(input bit rn, input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        bit forced, ra, rb;
        @(posedge clk);
        #1;
        reset_n     = rn;
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
        @(negedge clk);
        forced = (lost == LIMIT);
        ra = rn && !forced;
        rb = rn && (forced || !av);
        chk("a_ready", 64'(bus.a_ready), 64'(ra));
        chk("b_ready", 64'(bus.b_ready), 64'(rb));
        chk("a_stall", 64'(bus.a_stall), 64'(av && !ra));
        got_a = av && ra;
        got_b = !got_a && bv && rb;
        if (got_a) record(aa, ad);
        else if (got_b) record(ba, bd);
        if (!rn || !bv || got_b) lost = 0;
        else if (lost < LIMIT) lost++;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Shadow regfile: commits on negedge like the real one.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) rf_mem[bus.rf_wa] <= bus.rf_wd;
    end

    // Monitor: every presented write must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #3;
            if (bus.rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=r%0d<=%0h required=no write", bus.rf_wa, bus.rf_wd);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_wa", 64'(bus.rf_wa), 64'(e.addr));
                    chk("rf_wd", 64'(bus.rf_wd), 64'(e.data));
                end
            end
        end
    end

    initial begin
        int na, nb, first_b;
        bit bpend;
        logic [AW-1:0] bpa;
        logic [DW-1:0] bpd;
        bit rn, av;

        for (int i = 0; i < 32; i++) begin
            rf_mem[i] = '0;
            ref_rf[i] = '0;
        end
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;

        // Reset held two cycles with A requesting: nothing accepted, outputs cleared.
        step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b0, '0, '0);
        step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b0, '0, '0);
        chk("reset_rf_we", 64'(bus.rf_we), 64'd0);
        chk("reset_rf_wa", 64'(bus.rf_wa), 64'd0);
        chk("reset_rf_wd", 64'(bus.rf_wd), 64'd0);

        // Writeback alone, then the multi-cycle unit alone, then a write to r0.
        step(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
        idle();
        idle();
        chk("r5_after_write", 64'(rf_mem[5]), 64'hDEAD_BEEF);
        step(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 32'h1234_5678);
        idle();
        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0);
        idle();
        chk("r0_rf_we", 64'(bus.rf_we), 64'd0);
        chk("r0_rf_wa", 64'(bus.rf_wa), 64'd0);
        chk("r0_rf_wd", 64'(bus.rf_wd), 64'hFFFF_FFFF);

        // Sustained contention from a fresh reset: A,A,A,A,B,A,A,A,A,B.
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        na = 0; nb = 0; first_b = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, AW'(i + 1), $urandom, 1'b1, 5'd7, 32'h0B0B_0007);
            if (bus.a_ready === 1'b1) na++;
            if (bus.b_ready === 1'b1) begin
                nb++;
                if (first_b < 0) first_b = i;
            end
        end
        chk("contention_a_grants", 64'(na), 64'd8);
        chk("contention_b_grants", 64'(nb), 64'd2);
        chk("contention_first_b", 64'(first_b), 64'd4);
        idle();
`ifdef RF_WR_STATS_EN
        chk("stat_a_grants", 64'(sa), 64'd8);
        chk("stat_b_grants", 64'(sb), 64'd2);
        chk("stat_stall_cycles", 64'(ss), 64'd2);
`endif

        // Randomized traffic with occasional mid-operation resets; B holds its request.
        bpend = 1'b0; bpa = '0; bpd = '0;
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 31) != 0);
            av = ($urandom_range(0, 3) != 0);
            if (!bpend && ($urandom_range(0, 1) == 1)) begin
                bpend = 1'b1;
                bpa = AW'($urandom_range(0, 31));
                bpd = $urandom;
            end
            step(rn, av, AW'($urandom_range(0, 31)), $urandom, bpend, bpa, bpd);
            if (got_b) bpend = 1'b0;
        end

        bpend = 1'b0;
        idle();
        idle();
        idle();
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("regfile_r%0d", i), 64'(rf_mem[i]), 64'(ref_rf[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
